alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle 16-bit ALU for the Basys 3 datapath.
//  - Takes one operation per valid/ready transfer and returns result and flags on a valid/ready output.
//  - Adds a multi-cycle shift-add MUL (full 2*WIDTH product) and a restoring DIVU (quotient/remainder).
//  - Sits between the CPU register-file read stage and the writeback stage.
// PARAMETERS
//  WIDTH  16  operand/result width; power of 2, >= 4; SHW = $clog2(WIDTH) is local
// PORTS
//  clk            in   1      system clock (100 MHz on Basys 3)
//  reset_n        in   1      asynchronous, active-low reset
//  in_valid       in   1      operation request valid
//  in_ready       out  1      block can accept a request this cycle
//  op_code        in   4      operation select (table below)
//  a              in   WIDTH  operand A
//  b              in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  out_valid      out  1      result/flags valid
//  out_ready      in   1      consumer accepts result
//  result         out  WIDTH  primary result (MUL low half, DIVU quotient)
//  result_hi      out  WIDTH  MUL high half / DIVU remainder; 0 for all other ops
//  zero_flag      out  1      result == 0
//  carry_flag     out  1      carry / borrow / shifted-out bit (per op)
//  overflow_flag  out  1      signed overflow (per op)
//  negative_flag  out  1      result[WIDTH-1]
//  div0_flag      out  1      DIVU with b == 0
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Op codes:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR (logical), 8 CMPEQ, 9 CMPLT (signed),
//   A CMPLE (signed), B MUL (unsigned), C DIVU, D SRA (arithmetic), E CMPLTU (unsigned).
//   F is reserved: result 0, all flags 0.
//  Compares: result = {0.., cond}.
//  Operand capture: a, b and op_code are registered on acceptance (in_valid && in_ready).
//   Inputs may change freely afterwards.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: on accept, single-cycle ops (and DIVU with b==0) -> DONE; MUL/DIVU -> CALC with counter = WIDTH.
//   - CALC: one shift-add / restore-subtract step per cycle; counter decrements; on 1 -> DONE.
//   - DONE: out_valid=1; on out_ready -> IDLE, or straight to the next op if a new accept happens the same cycle.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); it is 0 throughout CALC.
//  Latency (accept edge -> first edge where out_valid=1):
//   - single-cycle ops: 1 clk, giving 1 op/clk throughput when out_ready is held high.
//   - MUL / DIVU: WIDTH+1 clks.
//  Backpressure: while out_valid && !out_ready, result, result_hi and all flags are held stable.
//  Flags: zero_flag and negative_flag are computed from result for every op.
//   - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = sign(a)==sign(b) && sign(sum)!=sign(a).
//   - SUB: carry = borrow (a<b unsigned); overflow = sign(a)!=sign(b) && sign(diff)!=sign(a).
//   - SHL/SHR/SRA: carry = last bit shifted out; carry = 0 when amount==0. overflow = 0.
//   - MUL: carry = overflow = |result_hi.
//   - DIVU: carry = overflow = 0.
//   - DIVU with b==0: result = all ones, result_hi = a, div0_flag = 1, 1-clk latency.
//   - All other ops: carry = overflow = div0 = 0.
//  Reset (reset_n low, asynchronous):
//   - state -> IDLE; out_valid, result, result_hi and all flags -> 0; counter -> 0.
//   - Any in-flight MUL/DIVU is aborted; no out_valid is produced for it after release.
//   - in_ready is 1 in IDLE, including during reset.
// TESTING (WIDTH=16)
//  1. ADD 0x7FFF+0x0001 -> result 0x8000, overflow=1, carry=0, negative=1, out_valid 1 clk after accept.
//     SUB 0x0000-0x0001 -> 0xFFFF, carry=1, overflow=0.
//  2. MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, carry=overflow=1.
//     out_valid exactly 17 clks after accept; in_ready=0 for clks 1..16.
//  3. DIVU 100/7 -> result 14, result_hi 2, 17 clks.
//     DIVU 5/0 -> result 0xFFFF, result_hi 5, div0=1, out_valid 1 clk after accept.
//  4. SHL 0x8001 by 1 -> 0x0002, carry=1. SRA 0x8000 by 15 -> 0xFFFF, carry=0.
//     SHR by 0 -> a unchanged, carry=0. CMPLT 0xFFFF<0x0001 -> 1; CMPLTU same operands -> 0.
//  5. Hold out_ready=0 for 5 clks after an ADD -> outputs stable, in_ready=0.
//     Then 8 back-to-back ADDs with out_ready=1 -> 8 results in 8 consecutive clks, in order.
//  6. Assert reset_n=0 at clk 8 of a MUL -> out_valid/result 0 immediately.
//     After release: no stale result; next ADD 2+3 -> 5, zero=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshaked request/response bundle for alu_seq.
// master: issues operations and consumes results (register-read / writeback side).
// slave : the ALU itself.
//   in_valid/in_ready, op_code, a, b           request channel
//   out_valid/out_ready, result, result_hi,    response channel
//   zero/carry/overflow/negative/div0 flags    response flags
//   busy                                       engine not idle
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             negative_flag;
  logic             div0_flag;
  logic             busy;

  modport master (
    output in_valid, op_code, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
           zero_flag, carry_flag, overflow_flag, negative_flag, div0_flag, busy
  );

  modport slave (
    input  in_valid, op_code, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
           zero_flag, carry_flag, overflow_flag, negative_flag, div0_flag, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift/compare ops plus
// multi-cycle shift-add MUL (full product) and restoring DIVU.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      alu_seq_if slave: request in, result/flags out, busy
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);

  localparam int unsigned W   = WIDTH;
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_NOT    = 4'h5;
  localparam logic [3:0] OP_SHL    = 4'h6;
  localparam logic [3:0] OP_SHR    = 4'h7;
  localparam logic [3:0] OP_CMPEQ  = 4'h8;
  localparam logic [3:0] OP_CMPLT  = 4'h9;
  localparam logic [3:0] OP_CMPLE  = 4'hA;
  localparam logic [3:0] OP_MUL    = 4'hB;
  localparam logic [3:0] OP_DIVU   = 4'hC;
  localparam logic [3:0] OP_SRA    = 4'hD;
  localparam logic [3:0] OP_CMPLTU = 4'hE;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic           multi;

  // Iterative engine: {acc_hi, acc_lo} is the MUL product / DIVU remainder:quotient pair
  logic [W-1:0]   acc_hi, acc_lo, opnd;
  logic           is_div;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   result_q, result_hi_q;
  logic           zero_q, carry_q, ovf_q, neg_q, div0_q;
  logic           out_valid_q, busy_q;

  // Single-cycle datapath, evaluated on the live request
  logic [W:0]     sum, diff, shl, shr, sra;
  logic [SHW-1:0] sh;
  logic [W-1:0]   sc_res, sc_hi;
  logic           sc_c, sc_v, sc_d0, sc_zn;

  // One MUL/DIVU iteration
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [W-1:0]   hi_n, lo_n;

  assign accept = bus.in_valid && bus.in_ready;
  assign multi  = (bus.op_code == OP_MUL) || ((bus.op_code == OP_DIVU) && (bus.b != '0));

  assign bus.in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid     = out_valid_q;
  assign bus.busy          = busy_q;
  assign bus.result        = result_q;
  assign bus.result_hi     = result_hi_q;
  assign bus.zero_flag     = zero_q;
  assign bus.carry_flag    = carry_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.negative_flag = neg_q;
  assign bus.div0_flag     = div0_q;

  // Single-cycle op results and flags
  always_comb begin
    sh     = bus.b[SHW-1:0];
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    diff   = {1'b0, bus.a} - {1'b0, bus.b};
    shl    = {1'b0, bus.a} << sh;
    // A guard bit below the LSB catches the last bit shifted out
    shr    = {bus.a, 1'b0} >> sh;
    sra    = (W+1)'($signed({bus.a, 1'b0}) >>> sh);
    sc_res = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_d0  = 1'b0;
    sc_zn  = 1'b1;
    case (bus.op_code)
      OP_ADD: begin
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
        sc_v   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        sc_res = diff[W-1:0];
        sc_c   = diff[W];
        sc_v   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      OP_AND:    sc_res = bus.a & bus.b;
      OP_OR:     sc_res = bus.a | bus.b;
      OP_XOR:    sc_res = bus.a ^ bus.b;
      OP_NOT:    sc_res = ~bus.a;
      OP_SHL: begin
        sc_res = shl[W-1:0];
        sc_c   = shl[W];
      end
      OP_SHR: begin
        sc_res = shr[W:1];
        sc_c   = shr[0];
      end
      OP_SRA: begin
        sc_res = sra[W:1];
        sc_c   = sra[0];
      end
      OP_CMPEQ:  sc_res = W'(bus.a == bus.b);
      OP_CMPLT:  sc_res = W'($signed(bus.a) < $signed(bus.b));
      OP_CMPLE:  sc_res = W'($signed(bus.a) <= $signed(bus.b));
      OP_CMPLTU: sc_res = W'(bus.a < bus.b);
      OP_DIVU: begin
        // Only reached here with b == 0
        sc_res = '1;
        sc_hi  = bus.a;
        sc_d0  = 1'b1;
      end
      default:   sc_zn = 1'b0;
    endcase
  end

  // One shift-add (MUL) or restore-subtract (DIVU) step
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[W-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = !div_diff[W];
    if (is_div) begin
      hi_n = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
      lo_n = {acc_lo[W-2:0], div_ge};
    end else begin
      {hi_n, lo_n} = {mul_sum, acc_lo[W-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                         state_nxt = multi ? CALC : DONE;
        else if (state == DONE && !bus.out_ready) state_nxt = DONE;
        else                                state_nxt = IDLE;
      end
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // Iterative engine and result/flag registers; results only change on load or finish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else if (accept) begin
      if (multi) begin
        acc_hi <= '0;
        acc_lo <= bus.a;
        opnd   <= bus.b;
        is_div <= (bus.op_code == OP_DIVU);
        cnt    <= CW'(W);
      end else begin
        result_q    <= sc_res;
        result_hi_q <= sc_hi;
        zero_q      <= sc_zn && (sc_res == '0);
        neg_q       <= sc_zn && sc_res[W-1];
        carry_q     <= sc_c;
        ovf_q       <= sc_v;
        div0_q      <= sc_d0;
      end
    end else if (state == CALC) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt - CW'(1);
      // Last step: publish straight from the step outputs
      if (cnt == CW'(1)) begin
        result_q    <= lo_n;
        result_hi_q <= hi_n;
        zero_q      <= (lo_n == '0);
        neg_q       <= lo_n[W-1];
        carry_q     <= !is_div && (hi_n != '0);
        ovf_q       <= !is_div && (hi_n != '0);
        div0_q      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors push expected
// responses; a negedge monitor pops and compares on every output transfer.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        v;
    logic        n;
    logic        d0;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  exp_t  sb[$];
  string sb_name[$];
  int    pop_cyc[$];

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic [15:0] h,
                              input logic z, input logic c, input logic v,
                              input logic n, input logic d);
    exp_t e;
    e.res = r; e.hi = h; e.z = z; e.c = c; e.v = v; e.n = n; e.d0 = d;
    return e;
  endfunction

  // Monitor: compare every transferred response against the scoreboard head
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(bus.out_valid), 64'd0);
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        chk(nm, 64'({bus.result, bus.result_hi, bus.zero_flag, bus.carry_flag,
                     bus.overflow_flag, bus.negative_flag, bus.div0_flag}), 64'(e));
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Present a request, wait for acceptance, push its expectation; returns at accept edge + 1
  task automatic send(input string nm, input logic [3:0] op, input logic [15:0] av,
                      input logic [15:0] bv, input exp_t e);
    int n = 0;
    bus.op_code  = op;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk({nm, "_accept_timeout"}, 64'(bus.in_ready), 64'd1);
    sb.push_back(e);
    sb_name.push_back(nm);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.op_code  = 4'($urandom);
  endtask

  // Called right after send(): count stall cycles, then require out_valid
  task automatic expect_latency(input string nm, input int lat);
    int stall = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (!bus.out_valid && !bus.in_ready) stall++;
    end
    @(negedge clk);
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (lat > 1) chk({nm, "_stall_cycles"}, 64'(stall), 64'(lat - 1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [36:0] snap;
    int          p0;
    int          stale;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_code   = 4'h0;
    bus.a         = 16'h0;
    bus.b         = 16'h0;

    #2;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'({bus.result, bus.result_hi}), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic with flag corners
    send("add_ovf", 4'h0, 16'h7FFF, 16'h0001, mk(16'h8000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    expect_latency("add_ovf", 1);
    send("sub_borrow", 4'h1, 16'h0000, 16'h0001, mk(16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    expect_latency("sub_borrow", 1);

    // Multi-cycle ops
    send("mul_1234", 4'hB, 16'h1234, 16'h0100, mk(16'h3400, 16'h0012, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    expect_latency("mul_1234", 17);
    send("mul_max", 4'hB, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    expect_latency("mul_max", 17);
    send("divu_100_7", 4'hC, 16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_latency("divu_100_7", 17);
    send("divu_by0", 4'hC, 16'd5, 16'd0, mk(16'hFFFF, 16'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_latency("divu_by0", 1);
    send("divu_ffff_10", 4'hC, 16'hFFFF, 16'h0010, mk(16'h0FFF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Shifts, compares and logic, issued back to back
    send("shl_8001_1",  4'h6, 16'h8001, 16'd1,  mk(16'h0002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    send("sra_8000_15", 4'hD, 16'h8000, 16'd15, mk(16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send("shr_by0",     4'h7, 16'h1234, 16'd0,  mk(16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send("shr_8003_1",  4'h7, 16'h8003, 16'd1,  mk(16'h4001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    send("cmplt_s",     4'h9, 16'hFFFF, 16'h0001, mk(16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send("cmpltu",      4'hE, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    send("cmple_eq",    4'hA, 16'h0005, 16'h0005, mk(16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send("cmpeq_ne",    4'h8, 16'h0005, 16'h0006, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    send("and",         4'h2, 16'hFF0F, 16'h0F0F, mk(16'h0F0F, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send("xor_self",    4'h4, 16'hAAAA, 16'hAAAA, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    send("not",         4'h5, 16'h00FF, 16'h1234, mk(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    drain();

    // Backpressure: result held while out_ready is low
    bus.out_ready = 1'b0;
    send("add_bp", 4'h0, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    snap = {bus.result, bus.result_hi, bus.zero_flag, bus.carry_flag,
            bus.overflow_flag, bus.negative_flag, bus.div0_flag};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.zero_flag,
                          bus.carry_flag, bus.overflow_flag, bus.negative_flag, bus.div0_flag}),
          64'({1'b1, 1'b0, snap}));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Eight back-to-back single-cycle ops must stream one per clock
    p0 = pop_cyc.size();
    for (int i = 0; i < 8; i++)
      send("add_b2b", 4'h0, 16'(i), 16'd10, mk(16'(i + 10), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    chk("b2b_count", 64'(pop_cyc.size() - p0), 64'd8);
    if (pop_cyc.size() >= p0 + 8)
      chk("b2b_span", 64'(pop_cyc[p0 + 7] - pop_cyc[p0]), 64'd7);

    // Reset in the middle of a MUL aborts it
    send("mul_abort", 4'hB, 16'h0003, 16'h0005, mk(16'h000F, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_result",    64'({bus.result, bus.result_hi}), 64'd0);
    chk("abort_in_ready",  64'(bus.in_ready), 64'd1);
    void'(sb.pop_back());
    void'(sb_name.pop_back());
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale_valid", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    send("add_2_3", 4'h0, 16'd2, 16'd3, mk(16'd5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_latency("add_2_3", 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
